// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store bus master.
// Issues word-aligned requests with byte enables and stalls the pipeline until
// BusAck or timeout. Also registers the raw read word and its type/offset for W.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        FlushM,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWData,
  output logic        StallM,
  output logic        AdelM,
  output logic        AdesM,
  output logic        BusErr,
  output logic [31:0] ReadDataW,
  output logic [2:0]  LoadTypeW,
  output logic [1:0]  TwoBit,
  output logic        LoadValidW
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state, state_next;
  logic [TO_W-1:0] cnt;
  logic            mis, acc;
  logic            start, done, abort;
  logic [3:0]      be_next;
  logic [31:0]     wdata_next;

  // Alignment check; a load takes priority over a store when both are set.
  always_comb begin
    mis = 1'b0;
    if (MemReadM) begin
      case (LoadTypeM)
        3'd1, 3'd2: mis = ALUOutM[0];
        3'd3, 3'd4: mis = 1'b0;
        default:    mis = |ALUOutM[1:0];
      endcase
    end else begin
      case (StoreTypeM)
        2'd1:    mis = ALUOutM[0];
        2'd2:    mis = 1'b0;
        default: mis = |ALUOutM[1:0];
      endcase
    end
  end

  assign acc   = (MemReadM | MemWriteM) & ~FlushM & ~mis;
  assign AdelM = MemReadM & ~FlushM & mis;
  assign AdesM = MemWriteM & ~MemReadM & ~FlushM & mis;

  // Byte enables and lane-replicated write data for the pending access.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = '0;
    if (!MemReadM) begin
      case (StoreTypeM)
        2'd1: begin
          be_next    = ALUOutM[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{WriteDataM[15:0]}};
        end
        2'd2: begin
          be_next    = 4'b0001 << ALUOutM[1:0];
          wdata_next = {4{WriteDataM[7:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = WriteDataM;
        end
      endcase
    end
  end

  // Next-state and stall decode; FlushM is ignored once a request is on the bus.
  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          StallM     = 1'b1;
          start      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (BusAck) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and cycles-in-REQ counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        cnt <= '0;
      end else if (state == REQ && StallM) begin
        cnt <= cnt + TO_W'(1);
      end
    end
  end

  // Bus request registers: captured on issue, held until ack or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BusReq   <= 1'b0;
      BusWe    <= 1'b0;
      BusAddr  <= '0;
      BusBe    <= '0;
      BusWData <= '0;
    end else if (start) begin
      BusReq   <= 1'b1;
      BusWe    <= ~MemReadM;
      BusAddr  <= {ALUOutM[31:2], 2'b00};
      BusBe    <= be_next;
      BusWData <= wdata_next;
    end else if (done || abort) begin
      BusReq <= 1'b0;
    end
  end

  // W-stage registers advance on every unstalled edge; BusErr pulses on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadDataW  <= '0;
      LoadTypeW  <= '0;
      TwoBit     <= '0;
      LoadValidW <= 1'b0;
      BusErr     <= 1'b0;
    end else begin
      BusErr <= abort;
      if (!StallM) begin
        LoadTypeW <= LoadTypeM;
        TwoBit    <= ALUOutM[1:0];
        if (done && !BusWe) begin
          ReadDataW  <= BusRData;
          LoadValidW <= 1'b1;
        end else begin
          ReadDataW  <= '0;
          LoadValidW <= 1'b0;
        end
      end else begin
        LoadValidW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests
// and load results; a monitor pops and compares when the DUT presents them.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, FlushM = 1'b0;
  logic [2:0]  LoadTypeM = '0;
  logic [1:0]  StoreTypeM = '0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0;
  logic        BusAck;
  logic [31:0] BusRData;
  logic        BusReq, BusWe, StallM, AdelM, AdesM, BusErr, LoadValidW;
  logic [31:0] BusAddr, BusWData, ReadDataW;
  logic [3:0]  BusBe;
  logic [2:0]  LoadTypeW;
  logic [1:0]  TwoBit;

  mem_access_unit #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .FlushM(FlushM), .BusAck(BusAck), .BusRData(BusRData),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
    .BusWData(BusWData), .StallM(StallM), .AdelM(AdelM), .AdesM(AdesM),
    .BusErr(BusErr), .ReadDataW(ReadDataW), .LoadTypeW(LoadTypeW),
    .TwoBit(TwoBit), .LoadValidW(LoadValidW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } bus_t;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  two;
    logic [2:0]  lt;
  } ld_t;

  bus_t        exp_bus[$];
  ld_t         exp_ld[$];
  int unsigned dly_q[$];
  int          total = 0, bad = 0;
  int          exp_err = 0, obs_err = 0;

  // Reference memory is byte-addressed; the slave keeps its own word memory.
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_byte({a[31:2], 2'b00} + 32'(k));
    return w;
  endfunction

  function automatic logic [31:0] bus_word(input logic [29:0] w);
    if (bus_mem.exists(w)) return bus_mem[w];
    return init_word(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    bus_mem[a[31:2]] = v;
    for (int k = 0; k < 4; k++) ref_mem[{a[31:2], 2'b00} + 32'(k)] = v[8*k +: 8];
  endtask

  // Issue one M-stage instruction and hold it while stalled; d = ack delay after BusReq.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] data, input logic flush,
                       input int unsigned d);
    int          sz, a, n, exp_stall;
    logic        mis, acc, is_store, tmo;
    bus_t        eb;
    ld_t         el;
    a = int'(addr[1:0]);
    if (rd) sz = (lt == 3'd1 || lt == 3'd2) ? 2 : (lt == 3'd3 || lt == 3'd4) ? 1 : 4;
    else    sz = (st == 2'd1) ? 2 : (st == 2'd2) ? 1 : 4;
    mis      = (a % sz) != 0;
    is_store = wr && !rd;
    acc      = (rd || wr) && !flush && !mis;
    tmo      = acc && (d >= TO);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; LoadTypeM = lt; StoreTypeM = st;
    ALUOutM = addr; WriteDataM = data; FlushM = flush;
    if (acc) begin
      dly_q.push_back(d);
      eb.we = is_store; eb.addr = addr & ~32'h3; eb.be = '0; eb.wdata = '0; eb.wmask = '0;
      for (int k = 0; k < 4; k++) begin
        if (!is_store) eb.be[k] = 1'b1;
        else if (k >= a && k < a + sz) begin
          eb.be[k] = 1'b1;
          eb.wmask[8*k +: 8] = 8'hFF;
          eb.wdata[8*k +: 8] = data[8*(k-a) +: 8];
        end
      end
      exp_bus.push_back(eb);
      if (!tmo) begin
        if (is_store) begin
          for (int k = 0; k < sz; k++) ref_mem[addr + 32'(k)] = data[8*k +: 8];
        end else begin
          el.word = ref_word(addr); el.two = addr[1:0]; el.lt = lt;
          exp_ld.push_back(el);
        end
      end
    end
    @(negedge clk);
    chk("adel", 32'(AdelM), 32'(rd && !flush && mis));
    chk("ades", 32'(AdesM), 32'(wr && !rd && !flush && mis));
    n = 0;
    while (StallM && n < 40) begin
      n++;
      @(posedge clk); #1;
      FlushM = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    exp_stall = !acc ? 0 : (tmo ? int'(TO) : int'(d) + 1);
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    if (tmo) begin
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0; FlushM = 1'b0;
      @(negedge clk);
      chk("bus_err", 32'(BusErr), 32'd1);
      chk("tmo_rdata", ReadDataW, 32'd0);
      chk("tmo_valid", 32'(LoadValidW), 32'd0);
      exp_err++;
    end
  endtask

  // Bus slave: acks after the queued delay, drops its transaction on abort/reset,
  // and fires stray acks while idle (the DUT must ignore them).
  initial begin : slave
    int unsigned cnt;
    bit          busy;
    logic [31:0] w;
    BusAck = 1'b0; BusRData = '0; busy = 0; cnt = 0;
    forever begin
      @(posedge clk); #2;
      BusAck = 1'b0; BusRData = '0;
      if (!rst_n) busy = 0;
      else begin
        if (busy && !BusReq) busy = 0;
        if (BusReq && !busy) begin
          busy = 1;
          if (dly_q.size() > 0) cnt = dly_q.pop_front();
          else cnt = 0;
        end
        if (busy) begin
          if (cnt == 0) begin
            BusAck = 1'b1;
            w = bus_word(BusAddr[31:2]);
            if (BusWe) begin
              for (int k = 0; k < 4; k++) if (BusBe[k]) w[8*k +: 8] = BusWData[8*k +: 8];
              bus_mem[BusAddr[31:2]] = w;
            end else begin
              BusRData = w;
            end
            busy = 0;
          end else begin
            cnt--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          BusAck = 1'b1;
          BusRData = $urandom;
        end
      end
    end
  end

  // Monitor: compares each new bus request and each completed load against the queues.
  initial begin : monitor
    logic req_prev;
    bus_t eb;
    ld_t  el;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (BusReq && !req_prev) begin
        if (exp_bus.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: got request addr %h expected none at %0t", BusAddr, $time);
        end else begin
          eb = exp_bus.pop_front();
          chk("bus_we", 32'(BusWe), 32'(eb.we));
          chk("bus_addr", BusAddr, eb.addr);
          chk("bus_be", 32'(BusBe), 32'(eb.be));
          if (eb.we) chk("bus_wdata", BusWData & eb.wmask, eb.wdata);
        end
      end
      req_prev = BusReq;
      if (LoadValidW) begin
        if (exp_ld.size() == 0) begin
          total++; bad++;
          $display("FAIL load_unexpected: got data %h expected none at %0t", ReadDataW, $time);
        end else begin
          el = exp_ld.pop_front();
          chk("load_data", ReadDataW, el.word);
          chk("load_twobit", 32'(TwoBit), 32'(el.two));
          chk("load_type", 32'(LoadTypeW), 32'(el.lt));
        end
      end
      if (BusErr) obs_err++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned op, d;
    int          sz, a;
    logic        rd, wr, fl;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] addr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({BusReq, BusWe, BusErr, LoadValidW, StallM}), 32'd0);
    chk("rst_addr", BusAddr, 32'd0);
    chk("rst_rdata", ReadDataW, 32'd0);
    chk("rst_wfields", 32'({LoadTypeW, TwoBit, BusBe}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(BusReq), 32'd0);

    // lw with ack one cycle after BusReq
    poke(32'h100, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 3'd0, 2'd0, 32'h100, 32'h0, 1'b0, 1);
    // sb lane 3, sh upper half: check full replicated data while the request is held
    do_op(1'b0, 1'b1, 3'd0, 2'd2, 32'h203, 32'h0000_00A5, 1'b0, 0);
    chk("sb_wdata", BusWData, 32'hA5A5_A5A5);
    chk("sb_be", 32'(BusBe), 32'b1000);
    do_op(1'b0, 1'b1, 3'd0, 2'd1, 32'h102, 32'h0000_1234, 1'b0, 0);
    chk("sh_wdata", BusWData, 32'h1234_1234);
    chk("sh_be", 32'(BusBe), 32'b1100);
    // misaligned load and store
    do_op(1'b1, 1'b0, 3'd1, 2'd0, 32'h101, 32'h0, 1'b0, 0);
    do_op(1'b0, 1'b1, 3'd0, 2'd0, 32'h102, 32'h0, 1'b0, 0);
    // timeout, ack on the last allowed cycle, flushed load
    do_op(1'b1, 1'b0, 3'd0, 2'd0, 32'h100, 32'h0, 1'b0, 20);
    do_op(1'b1, 1'b0, 3'd0, 2'd0, 32'h100, 32'h0, 1'b0, TO - 1);
    do_op(1'b1, 1'b0, 3'd0, 2'd0, 32'h100, 32'h0, 1'b1, 0);

    // reset asserted mid-request drops BusReq at once
    @(posedge clk); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; LoadTypeM = 3'd0; ALUOutM = 32'h140; FlushM = 1'b0;
    exp_bus.push_back('{we: 1'b0, addr: 32'h140, be: 4'hF, wdata: 32'h0, wmask: 32'h0});
    dly_q.push_back(100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("req_before_rst", 32'(BusReq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("req_async_rst", 32'(BusReq), 32'd0);
    chk("err_async_rst", 32'({BusErr, LoadValidW}), 32'd0);
    MemReadM = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      op = $urandom_range(0, 7);
      rd = 1'b0; wr = 1'b0; lt = '0; st = '0;
      if (op < 5) begin
        rd = 1'b1;
        lt = 3'(op);
        if (op == 0 && $urandom_range(0, 3) == 0) lt = 3'($urandom_range(5, 7));
        if ($urandom_range(0, 15) == 0) wr = 1'b1;
        st = 2'($urandom_range(0, 3));
      end else begin
        wr = 1'b1;
        if (op == 5) st = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd0;
        else st = 2'(op - 5);
        lt = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 19) == 0) begin rd = 1'b0; wr = 1'b0; end
      if (rd) sz = (lt == 3'd1 || lt == 3'd2) ? 2 : (lt == 3'd3 || lt == 3'd4) ? 1 : 4;
      else    sz = (st == 2'd1) ? 2 : (st == 2'd2) ? 1 : 4;
      a = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      addr = 32'h1000 + 32'(4 * int'($urandom_range(0, 7)) + a);
      fl = ($urandom_range(0, 9) == 0);
      d = $urandom_range(0, 7);
      do_op(rd, wr, lt, st, addr, $urandom, fl, d);
    end

    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0; FlushM = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
    chk("load_queue_drained", 32'(exp_ld.size()), 32'd0);
    chk("bus_err_count", 32'(obs_err), 32'(exp_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
